// File: rtl/connect4_move_sequencer.sv
// connect4_move_sequencer
//   Owns the Connect-4 board. Accepts one one-hot column request at a time
//   and drops the mover's token into the lowest free row, one row per cycle.
//   It then scans every anchor cell, one per cycle, for four in a row and
//   either hands the turn to the other player or ends the game.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-low reset
//   new_game    synchronous board clear; overrides everything except rst
//   play        one-hot column request (bit 0 = leftmost column)
//   play_valid  play is meaningful this cycle
//   play_ready  high in IDLE; a move is accepted on play_valid && play_ready
//   panel       [row][col] cell codes: 00 empty, 01 player 0, 10 player 1
//   player      player to move next
//   winner      00 none, 01 player 0, 10 player 1, 11 draw
//   game_over   high while the game is finished
//   move_done   one-cycle pulse after a legal move is fully processed
//   illegal     one-cycle pulse when a move is rejected
//   busy        high while dropping or scanning
module connect4_move_sequencer #(
    parameter int   ROWS         = 6,
    parameter int   COLS         = 7,
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          new_game,
    input  logic [COLS-1:0]               play,
    input  logic                          play_valid,
    output logic                          play_ready,
    output logic [ROWS-1:0][COLS-1:0][1:0] panel,
    output logic                          player,
    output logic [1:0]                    winner,
    output logic                          game_over,
    output logic                          move_done,
    output logic                          illegal,
    output logic                          busy
);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, DROP, CHECK, OVER} state_t;
    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    state_t         state_reg, state_next;
    board_t         panel_reg, panel_next;
    logic           player_reg, player_next;
    logic           mover_reg, mover_next;
    logic [1:0]     winner_reg, winner_next;
    logic [CW-1:0]  col_reg, col_next;
    logic [RW-1:0]  row_reg, row_next;
    logic [RW-1:0]  anchor_row_reg, anchor_row_next;
    logic [CW-1:0]  anchor_col_reg, anchor_col_next;
    logic [5:0]     move_count_reg, move_count_next;
    logic           move_done_reg, move_done_next;
    logic           illegal_reg, illegal_next;

    logic [1:0]     mover_code;
    logic           play_one_hot;
    logic [CW-1:0]  play_col;
    int             anchor_r, anchor_c;
    logic [3:0]     horiz_m, vert_m, upright_m, upleft_m;
    logic           anchor_hit;

    // Off-board positions never match, which drops directions leaving the board.
    function automatic logic cell_match(input board_t b, input int r, input int c,
                                        input logic [1:0] code);
        logic hit;
        hit = 1'b0;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
            hit = (b[r[RW-1:0]][c[CW-1:0]] == code);
        return hit;
    endfunction

    assign mover_code   = mover_reg ? 2'b10 : 2'b01;
    assign play_one_hot = (play != '0) && ((play & (play - COLS'(1))) == '0);
    assign anchor_r     = int'(anchor_row_reg);
    assign anchor_c     = int'(anchor_col_reg);

    always_comb begin
        play_col = '0;
        for (int i = 0; i < COLS; i++)
            if (play[i]) play_col = CW'(i);
    end

    // Four cells per direction starting at the current anchor.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_span
            assign horiz_m[gi]   = cell_match(panel_reg, anchor_r,      anchor_c + gi, mover_code);
            assign vert_m[gi]    = cell_match(panel_reg, anchor_r + gi, anchor_c,      mover_code);
            assign upright_m[gi] = cell_match(panel_reg, anchor_r + gi, anchor_c + gi, mover_code);
            assign upleft_m[gi]  = cell_match(panel_reg, anchor_r + gi, anchor_c - gi, mover_code);
        end
    endgenerate

    assign anchor_hit = (&horiz_m) | (&vert_m) | (&upright_m) | (&upleft_m);

    always_comb begin
        state_next      = state_reg;
        panel_next      = panel_reg;
        player_next     = player_reg;
        mover_next      = mover_reg;
        winner_next     = winner_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        anchor_row_next = anchor_row_reg;
        anchor_col_next = anchor_col_reg;
        move_count_next = move_count_reg;
        move_done_next  = 1'b0;
        illegal_next    = 1'b0;

        if (new_game) begin
            // Same clear as reset; any move offered this cycle is dropped silently.
            state_next      = IDLE;
            panel_next      = '0;
            player_next     = FIRST_PLAYER;
            winner_next     = 2'b00;
            move_count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (play_valid) begin
                        if (play_one_hot) begin
                            col_next   = play_col;
                            mover_next = player_reg;
                            row_next   = '0;
                            state_next = DROP;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (panel_reg[row_reg][col_reg] == 2'b00) begin
                        panel_next[row_reg][col_reg] = mover_code;
                        move_count_next = move_count_reg + 6'd1;
                        anchor_row_next = '0;
                        anchor_col_next = '0;
                        state_next      = CHECK;
                    end else if (row_reg == RW'(ROWS - 1)) begin
                        // Column full: nothing was written, turn stays with the mover.
                        illegal_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        row_next = row_reg + RW'(1);
                    end
                end
                CHECK: begin
                    if (anchor_hit) begin
                        winner_next    = mover_code;
                        move_done_next = 1'b1;
                        state_next     = OVER;
                    end else if (anchor_row_reg == RW'(ROWS - 1) &&
                                 anchor_col_reg == CW'(COLS - 1)) begin
                        move_done_next = 1'b1;
                        if (move_count_reg == 6'(CELLS)) begin
                            winner_next = 2'b11;
                            state_next  = OVER;
                        end else begin
                            player_next = ~player_reg;
                            state_next  = IDLE;
                        end
                    end else if (anchor_col_reg == CW'(COLS - 1)) begin
                        anchor_col_next = '0;
                        anchor_row_next = anchor_row_reg + RW'(1);
                    end else begin
                        anchor_col_next = anchor_col_reg + CW'(1);
                    end
                end
                OVER: begin
                    state_next = OVER;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            panel_reg      <= '0;
            player_reg     <= FIRST_PLAYER;
            mover_reg      <= FIRST_PLAYER;
            winner_reg     <= 2'b00;
            col_reg        <= '0;
            row_reg        <= '0;
            anchor_row_reg <= '0;
            anchor_col_reg <= '0;
            move_count_reg <= '0;
            move_done_reg  <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            panel_reg      <= panel_next;
            player_reg     <= player_next;
            mover_reg      <= mover_next;
            winner_reg     <= winner_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            anchor_row_reg <= anchor_row_next;
            anchor_col_reg <= anchor_col_next;
            move_count_reg <= move_count_next;
            move_done_reg  <= move_done_next;
            illegal_reg    <= illegal_next;
        end
    end

    assign play_ready = (state_reg == IDLE);
    assign busy       = (state_reg == DROP) || (state_reg == CHECK);
    assign game_over  = (state_reg == OVER);
    assign panel      = panel_reg;
    assign player     = player_reg;
    assign winner     = winner_reg;
    assign move_done  = move_done_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_connect4_move_sequencer.sv
// Testbench for connect4_move_sequencer: table of single moves with
// hand-derived row, latency, winner and next player, plus hand-written
// sequences for OVER lock-out, new_game and reset in the middle of a move.
module tb_connect4_move_sequencer;
    localparam int ROWS = 6;
    localparam int COLS = 7;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    typedef struct {
        bit         ng;      // issue new_game before this move
        logic [6:0] play;
        bit         legal;
        logic [2:0] row;
        int         lat;     // negedges after accept edge until the pulse is seen
        logic [1:0] win;
        bit         plr;
        bit         over;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, new_game, play_valid;
    logic [6:0] play;
    logic       play_ready, player, game_over, move_done, illegal, busy;
    logic [1:0] winner;
    board_t     panel;

    int     checks = 0;
    int     errors = 0;
    board_t model;
    bit     mover;
    vec_t   vecs[$];

    connect4_move_sequencer #(.ROWS(ROWS), .COLS(COLS), .FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .play(play),
        .play_valid(play_valid), .play_ready(play_ready), .panel(panel),
        .player(player), .winner(winner), .game_over(game_over),
        .move_done(move_done), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] col_of(input logic [6:0] p);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++)
            if (p[i]) c = 3'(i);
        return c;
    endfunction

    task automatic add(input bit ng, input logic [6:0] p, input bit legal, input int row,
                       input int lat, input logic [1:0] win, input bit plr, input bit over);
        vec_t v;
        v.ng = ng; v.play = p; v.legal = legal; v.row = 3'(row); v.lat = lat;
        v.win = win; v.plr = plr; v.over = over;
        vecs.push_back(v);
    endtask

    task automatic clear_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        model = '0;
        mover = 1'b0;
    endtask

    // Offers one move and waits (bounded) for move_done or illegal.
    task automatic do_move(input logic [6:0] p, input bit legal, input logic [2:0] row,
                           output int lat, output bit done, output bit ill,
                           output int land, output bit pulse_after);
        logic [2:0] c;
        c = col_of(p);
        lat = -1; done = 1'b0; ill = 1'b0; land = -1;
        @(negedge clk);
        play = p; play_valid = 1'b1;
        @(posedge clk);
        #1 play_valid = 1'b0; play = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (land < 0 && legal && panel[row][c] != 2'b00) land = i;
            if (move_done || illegal) begin
                lat = i; done = move_done; ill = illegal;
                break;
            end
        end
        if (lat < 0) chk("timeout", 1'b1, 1'b0);
        @(negedge clk);
        pulse_after = move_done | illegal;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_panel"}, 96'(panel), 96'(0));
        chk({tag, "_player"}, player, 1'b0);
        chk({tag, "_winner"}, winner, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ready"}, play_ready, 1'b1);
        chk({tag, "_count"}, dut.move_count_reg, 6'd0);
    endtask

    initial begin
        int  lat, land, mcount;
        bit  done, ill, pa_after;
        int  pa[3];
        int  pb[3];
        logic [2:0] c;

        rst = 1'b0; new_game = 1'b0; play = '0; play_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", play_ready, 1'b1);
        chk("rst_over", game_over, 1'b0);
        chk("rst_done", move_done, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        check_cleared("rst");

        // Game 1: single move into column 3.
        add(1, 7'b0001000, 1, 0, 44, 2'b00, 1, 0);
        // Game 2: players alternate cols 0/1; player 0 wins vertically at anchor 0.
        add(1, 7'b0000001, 1, 0, 44, 2'b00, 1, 0);
        add(0, 7'b0000010, 1, 0, 44, 2'b00, 0, 0);
        add(0, 7'b0000001, 1, 1, 45, 2'b00, 1, 0);
        add(0, 7'b0000010, 1, 1, 45, 2'b00, 0, 0);
        add(0, 7'b0000001, 1, 2, 46, 2'b00, 1, 0);
        add(0, 7'b0000010, 1, 2, 46, 2'b00, 0, 0);
        add(0, 7'b0000001, 1, 3, 6,  2'b01, 0, 1);
        // Game 3: fill column 2, then overfill; then non-one-hot requests.
        for (int r = 0; r < 6; r++)
            add(r == 0, 7'b0000100, 1, r, 44 + r, 2'b00, (r % 2) == 0, 0);
        add(0, 7'b0000100, 0, 0, 7, 2'b00, 0, 0);
        add(0, 7'b0000011, 0, 0, 1, 2'b00, 0, 0);
        add(0, 7'b0000000, 0, 0, 1, 2'b00, 0, 0);
        // Game 4: 42-move draw. Column pairs (a,b) played a,b,b,a,... then column 5 alone.
        pa = '{0, 1, 4};
        pb = '{2, 3, 6};
        mcount = 0;
        for (int p = 0; p < 3; p++)
            for (int j = 0; j < 12; j++) begin
                c = 3'((j % 4 == 0 || j % 4 == 3) ? pa[p] : pb[p]);
                mcount++;
                add(mcount == 1, 7'(7'd1 << c), 1, j / 2, 44 + j / 2, 2'b00, (mcount % 2) == 1, 0);
            end
        for (int j = 0; j < 6; j++) begin
            mcount++;
            if (mcount == 42) add(0, 7'b0100000, 1, j, 44 + j, 2'b11, 1, 1);
            else              add(0, 7'b0100000, 1, j, 44 + j, 2'b00, (mcount % 2) == 1, 0);
        end

        foreach (vecs[k]) begin
            if (vecs[k].ng) clear_game();
            chk("pre_ready", play_ready, 1'b1);
            do_move(vecs[k].play, vecs[k].legal, vecs[k].row, lat, done, ill, land, pa_after);
            $display("move %0d play=%b lat=%0d done=%0b illegal=%0b winner=%b player=%0b",
                     k, vecs[k].play, lat, done, ill, winner, player);
            if (vecs[k].legal) begin
                model[vecs[k].row][col_of(vecs[k].play)] = mover ? 2'b10 : 2'b01;
                chk("land_cycle", 96'(land), 96'(vecs[k].row + 2));
            end
            chk("done", done, vecs[k].legal);
            chk("illegal", ill, !vecs[k].legal);
            chk("latency", 96'(lat), 96'(vecs[k].lat));
            chk("one_cycle_pulse", pa_after, 1'b0);
            chk("winner", winner, vecs[k].win);
            chk("player", player, vecs[k].plr);
            chk("game_over", game_over, vecs[k].over);
            chk("ready_after", play_ready, !vecs[k].over);
            chk("busy_after", busy, 1'b0);
            chk("panel", 96'(panel), 96'(model));
            mover = vecs[k].plr;

            // After the vertical win, OVER must ignore further requests.
            if (k == 7) begin
                @(negedge clk);
                play = 7'b0010000; play_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("over_no_illegal", illegal, 1'b0);
                    chk("over_no_done", move_done, 1'b0);
                end
                play_valid = 1'b0; play = '0;
                chk("over_panel_frozen", 96'(panel), 96'(model));
                chk("over_ready", play_ready, 1'b0);
                chk("over_game_over", game_over, 1'b1);
                chk("over_winner", winner, 2'b01);
            end
        end

        // new_game in IDLE with a concurrent non-one-hot move: no illegal pulse.
        clear_game();
        do_move(7'b0000001, 1, 3'd0, lat, done, ill, land, pa_after);
        chk("pre_ng_count", dut.move_count_reg, 6'd1);
        @(negedge clk);
        new_game = 1'b1; play = 7'b0000011; play_valid = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0; play_valid = 1'b0; play = '0;
        @(negedge clk);
        chk("ng_idle_no_illegal", illegal, 1'b0);
        check_cleared("ng_idle");
        $display("new_game in IDLE with offered move: illegal=%0b busy=%0b", illegal, busy);

        // new_game with a one-hot move offered: the move is dropped.
        new_game = 1'b1; play = 7'b0010000; play_valid = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0; play_valid = 1'b0; play = '0;
        repeat (5) @(negedge clk);
        check_cleared("ng_onehot");

        // new_game in the middle of CHECK.
        @(negedge clk);
        play = 7'b0001000; play_valid = 1'b1;
        @(posedge clk);
        #1 play_valid = 1'b0; play = '0;
        repeat (10) @(negedge clk);
        chk("mid_check_busy", busy, 1'b1);
        chk("mid_check_cell", panel[0][3], 2'b01);
        new_game = 1'b1; play = 7'b0000011; play_valid = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0; play_valid = 1'b0; play = '0;
        @(negedge clk);
        check_cleared("ng_check");
        for (int i = 0; i < 3; i++) begin
            chk("ng_check_no_illegal", illegal, 1'b0);
            chk("ng_check_no_done", move_done, 1'b0);
            @(negedge clk);
        end
        $display("new_game during CHECK: busy=%0b panel=%h", busy, panel);

        // rst low in the middle of DROP (column 6 holds three tokens).
        for (int i = 0; i < 3; i++)
            do_move(7'b1000000, 1, 3'(i), lat, done, ill, land, pa_after);
        chk("pre_rst_cell", panel[2][6], 2'b01);
        @(negedge clk);
        play = 7'b1000000; play_valid = 1'b1;
        @(posedge clk);
        #1 play_valid = 1'b0; play = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_drop_busy", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk) rst = 1'b1;
        check_cleared("rst_drop");
        chk("rst_drop_no_done", move_done, 1'b0);
        repeat (6) @(negedge clk);
        chk("rst_drop_stays_clear", 96'(panel), 96'(0));
        $display("rst during DROP: panel=%h player=%0b", panel, player);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
